i2c_write_scheduler: RTL and testbench
======================================

Name: i2c_write_scheduler

Overview:
- Round-robin scheduler that shares one single-write I2C master (7-bit address + 8-bit data, write-only) between NUM_REQ requesters.
- Latches the winning request, launches the master, and holds its address/data stable for the whole transfer.
- Detects completion by monitoring the master's scl/sda outputs, then pulses a per-requester done or error strobe.
- Re-arms the master with a synchronous reset pulse between transfers, because the master does not return to idle on its own.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, maximum cycles from launch to detected completion before the transfer is aborted.
- IDLE_CYCLES, 2, consecutive cycles with scl=1 and sda=1 that mark end of transfer.
- RST_CYCLES, 1, length of the master re-arm reset pulse.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-high (name kept per codebase convention despite polarity).
- req  in  NUM_REQ  level request per requester; hold until done/err.
- req_id  in  NUM_REQ*7  slave address per requester; requester i uses bits [7i+6:7i].
- req_data  in  NUM_REQ*8  write byte per requester; requester i uses bits [8i+7:8i].
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  NUM_REQ  one-cycle timeout pulse to the granted requester.
- busy  out  1  high in every state except IDLE.
- m_valid  out  1  launch strobe to the master.
- m_id  out  7  address to the master.
- m_data  out  8  data to the master.
- m_rst  out  1  synchronous active-high reset to the master.
- scl_mon  in  1  master scl, monitored.
- sda_mon  in  1  master sda, monitored.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - State=RECOVER, m_rst=1, m_valid=0, m_id=0, m_data=0, done=0, err=0, busy=1.
  - RR pointer set so requester 0 has highest priority; all counters cleared.
  - Reset mid-transfer aborts the transfer silently: no done/err pulse.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward (with wrap) from last_grant+1.
  - Latch grant index, m_id and m_data from that requester's slice; go to LAUNCH.
  - With no request, stay in IDLE; outputs unchanged, m_valid=0.
- LAUNCH:
  - m_valid=1 for exactly one cycle; clear the timeout counter and the seen_low flag.
  - Go to WAIT.
- WAIT:
  - m_id/m_data held constant for the whole state.
  - Timeout counter increments every cycle.
  - seen_low sets on the first cycle with scl_mon=0.
  - The idle counter counts consecutive cycles with seen_low=1 and scl_mon=1 and sda_mon=1; any other cycle clears it.
  - Idle counter reaches IDLE_CYCLES: done[grant]=1 for one cycle, last_grant=grant, go to RECOVER.
  - Else if the timeout counter reaches TIMEOUT_CYCLES: err[grant]=1 for one cycle, last_grant=grant, go to RECOVER.
  - If both conditions occur in the same cycle, done wins.
- RECOVER:
  - m_rst=1 for RST_CYCLES cycles, then go to IDLE with m_rst=0.
  - Earliest next m_valid is RST_CYCLES+2 cycles after the done/err pulse.
- Requests:
  - Deasserting req during WAIT does not cancel the transfer; done still pulses.
  - req changes on non-granted lines are ignored until IDLE.
- Fairness: with all NUM_REQ lines asserted continuously, grants rotate 0,1,2,…,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Pointer arithmetic: modulo NUM_REQ, index width $clog2(NUM_REQ). Timeout counter width $clog2(TIMEOUT_CYCLES+1).
- done and err are never asserted simultaneously; at most one bit of either vector is set in any cycle.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, RECOVER);
  - I2C_ID_W=7 and I2C_DATA_W=8;
  - the widths of the TIMEOUT_CYCLES, IDLE_CYCLES and RST_CYCLES counters.
- One sub-module: rr_arbiter_comb, combinational. Inputs: req vector, last_grant. Outputs: grant index and any_req.

Test Plan:
- Single request: req=4'b0010, req_id[13:7]=7'h3A, req_data[15:8]=8'hC5, scheduler driving the real master → m_valid pulses one cycle after req, m_id=7'h3A and m_data=8'hC5 stable through WAIT, done=4'b0010 pulse once, then m_rst pulse, then busy=0.
- Round-robin: req=4'b1111 held for 5 transfers, distinct ids 7'h10..7'h13 → grant order 0,1,2,3,0; each done bit pulses exactly in that order.
- Timeout: scl_mon tied 1, sda_mon tied 0, req=4'b0001 → err=4'b0001 exactly TIMEOUT_CYCLES (64) cycles after launch, no done, then m_rst=1 for 1 cycle.
- False end guard: before scl_mon first goes low, drive scl_mon=1, sda_mon=1 for 10 cycles after launch → no done (seen_low=0); after a later low pulse and 2 idle cycles → done.
- Reset mid-WAIT: rst_n=1 for one cycle during a transfer → no done/err, m_rst=1, m_valid=0, and requester 0 is granted first afterwards when req=4'b1001.
- Request drop: req[2] deasserted in WAIT → done[2] still pulses, and the next grant searches from index 3.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C write scheduler and its arbiter.
package i2c_pkg;

    localparam int I2C_ID_W   = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    // Width of a counter that must be able to hold the value max_count.
    function automatic int cnt_w(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    localparam int TIMEOUT_CNT_W = cnt_w(64);
    localparam int IDLE_CNT_W    = cnt_w(2);
    localparam int RST_CNT_W     = cnt_w(1);

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first set request searching upward from last_grant+1 with wrap.
module rr_arbiter_comb #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any_req
);

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            int idx;
            logic [IDX_W-1:0] sel;
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (!any_req && req[sel]) begin
                any_req = 1'b1;
                grant   = sel;
            end
        end
    end

endmodule

// File: rtl/i2c_write_scheduler.sv
// Shares one write-only I2C master between NUM_REQ requesters; detects the end of
// each transfer from scl/sda and re-arms the master with a reset pulse afterwards.
module i2c_write_scheduler
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int IDLE_CYCLES    = 2,
    parameter int RST_CYCLES     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*I2C_ID_W-1:0] req_id,
    input  logic [NUM_REQ*I2C_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          err,
    output logic                        busy,
    output logic                        m_valid,
    output logic [I2C_ID_W-1:0]         m_id,
    output logic [I2C_DATA_W-1:0]       m_data,
    output logic                        m_rst,
    input  logic                        scl_mon,
    input  logic                        sda_mon
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TO_W   = cnt_w(TIMEOUT_CYCLES);
    localparam int IDLE_W = cnt_w(IDLE_CYCLES);
    localparam int RST_W  = cnt_w(RST_CYCLES);

    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_DONE = IDLE_W'(IDLE_CYCLES);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

    state_t                  state;
    logic [IDX_W-1:0]        grant;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        arb_grant;
    logic                    any_req;
    logic [TO_W-1:0]         to_cnt;
    logic [IDLE_W-1:0]       idle_cnt;
    logic [IDLE_W-1:0]       idle_next;
    logic [RST_W-1:0]        rst_cnt;
    logic                    seen_low;
    logic                    idle_hit;
    logic                    to_hit;
    logic [I2C_ID_W-1:0]     sel_id;
    logic [I2C_DATA_W-1:0]   sel_data;

    rr_arbiter_comb #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_req    (any_req)
    );

    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant == IDX_W'(i)) begin
                sel_id   = req_id[i*I2C_ID_W +: I2C_ID_W];
                sel_data = req_data[i*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    // A bus-idle stretch only counts once the master has actually driven scl low,
    // otherwise the idle bus right after launch would look like a finished transfer.
    always_comb begin
        idle_next = (seen_low && scl_mon && sda_mon) ? idle_cnt + 1'b1 : '0;
        idle_hit  = (idle_next == IDLE_DONE);
        to_hit    = (to_cnt == TO_LAST);
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ST_RECOVER;
            m_rst      <= 1'b1;
            m_valid    <= 1'b0;
            m_id       <= '0;
            m_data     <= '0;
            done       <= '0;
            err        <= '0;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            to_cnt     <= '0;
            idle_cnt   <= '0;
            rst_cnt    <= '0;
            seen_low   <= 1'b0;
        end else begin
            done    <= '0;
            err     <= '0;
            m_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant   <= arb_grant;
                        m_id    <= sel_id;
                        m_data  <= sel_data;
                        m_valid <= 1'b1;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    to_cnt   <= '0;
                    idle_cnt <= '0;
                    seen_low <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    to_cnt   <= to_cnt + 1'b1;
                    idle_cnt <= idle_next;
                    if (!scl_mon) begin
                        seen_low <= 1'b1;
                    end
                    if (idle_hit) begin
                        done[grant] <= 1'b1;
                        last_grant  <= grant;
                        state       <= ST_RECOVER;
                    end else if (to_hit) begin
                        err[grant]  <= 1'b1;
                        last_grant  <= grant;
                        state       <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    // m_rst rises the cycle after done/err so the two never overlap.
                    if (!m_rst) begin
                        m_rst   <= 1'b1;
                        rst_cnt <= '0;
                    end else if (rst_cnt == RST_LAST) begin
                        m_rst   <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                default: state <= ST_RECOVER;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// Directed bench for i2c_write_scheduler; the bench plays the I2C master on scl_mon/sda_mon.
module tb_i2c_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [27:0] req_id;
    logic [31:0] req_data;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;
    logic        m_valid;
    logic [6:0]  m_id;
    logic [7:0]  m_data;
    logic        m_rst;
    logic        scl_mon;
    logic        sda_mon;

    int checks = 0;
    int errors = 0;

    i2c_write_scheduler #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (64),
        .IDLE_CYCLES    (2),
        .RST_CYCLES     (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_id   (req_id),
        .req_data (req_data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .m_valid  (m_valid),
        .m_id     (m_id),
        .m_data   (m_data),
        .m_rst    (m_rst),
        .scl_mon  (scl_mon),
        .sda_mon  (sda_mon)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ids();
        for (int i = 0; i < 4; i++) begin
            req_id[7*i +: 7]   = 7'(16 + i);
            req_data[8*i +: 8] = 8'(160 + i);
        end
    endtask

    task automatic wait_launch(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (m_valid === 1'b1) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
    endtask

    // Two scl-low cycles, then an idle bus until done or err shows up.
    task automatic finish_xfer(output logic [3:0] d, output logic [3:0] e, output bit ok);
        scl_mon = 1'b0;
        tick();
        tick();
        scl_mon = 1'b1;
        sda_mon = 1'b1;
        d  = '0;
        e  = '0;
        ok = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (done !== 4'b0 || err !== 4'b0) begin
                d  = done;
                e  = err;
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         n;
        int         lat;
        logic [3:0] d;
        logic [3:0] e;
        logic [3:0] seen;

        rst_n   = 1'b1;
        req     = '0;
        scl_mon = 1'b1;
        sda_mon = 1'b1;
        req_id  = '0;
        req_data = '0;
        set_ids();

        tick();
        chk("rst_m_rst", m_rst, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_id", m_id, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("post_rst_m_rst", m_rst, 0);
        chk("post_rst_busy", busy, 0);

        // Round robin with all four lines held: grants 0,1,2,3,0.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_launch(ok, n);
            chk("rr_launch", ok, 1);
            chk("rr_launch_gap", n, (k == 0) ? 1 : 3);
            chk("rr_id", m_id, 16 + (k % 4));
            chk("rr_data", m_data, 160 + (k % 4));
            finish_xfer(d, e, ok);
            chk("rr_complete", ok, 1);
            chk("rr_done", d, 1 << (k % 4));
            chk("rr_err", e, 0);
        end
        req = '0;
        tick();
        tick();
        chk("rr_idle_busy", busy, 0);

        // Single request on line 1 with a hand-picked id/data.
        req_id[13:7]   = 7'h3A;
        req_data[15:8] = 8'hC5;
        req = 4'b0010;
        tick();
        chk("single_m_valid", m_valid, 1);
        chk("single_m_id", m_id, 7'h3A);
        chk("single_m_data", m_data, 8'hC5);
        chk("single_busy", busy, 1);
        tick();
        chk("single_m_valid_low", m_valid, 0);
        scl_mon = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_hold_id", m_id, 7'h3A);
            chk("single_hold_data", m_data, 8'hC5);
        end
        scl_mon = 1'b1;
        sda_mon = 1'b0;
        tick();
        chk("single_no_done_sda_low", done, 0);
        sda_mon = 1'b1;
        tick();
        chk("single_no_done_idle1", done, 0);
        tick();
        chk("single_done", done, 4'b0010);
        chk("single_err", err, 0);
        chk("single_m_rst_at_done", m_rst, 0);
        req = '0;
        tick();
        chk("single_done_clear", done, 0);
        chk("single_m_rst", m_rst, 1);
        chk("single_busy_recover", busy, 1);
        tick();
        chk("single_m_rst_end", m_rst, 0);
        chk("single_busy_end", busy, 0);
        set_ids();

        // Timeout: sda stuck low so the bus never looks idle.
        scl_mon = 1'b1;
        sda_mon = 1'b0;
        req = 4'b0001;
        wait_launch(ok, n);
        chk("to_launch", ok, 1);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done !== 4'b0 || err !== 4'b0) begin
                lat = i;
                break;
            end
        end
        // LAUNCH cycle followed by 64 WAIT cycles.
        chk("to_latency", lat, 65);
        chk("to_err", err, 4'b0001);
        chk("to_no_done", done, 0);
        req = '0;
        tick();
        chk("to_err_clear", err, 0);
        chk("to_m_rst", m_rst, 1);
        tick();
        chk("to_m_rst_end", m_rst, 0);
        chk("to_busy_end", busy, 0);
        sda_mon = 1'b1;

        // False end guard: idle bus before any scl low must not complete.
        req = 4'b0001;
        wait_launch(ok, n);
        chk("fe_launch", ok, 1);
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | done | err;
        end
        chk("fe_no_early_done", seen, 0);
        scl_mon = 1'b0;
        tick();
        scl_mon = 1'b1;
        tick();
        chk("fe_no_done_idle1", done, 0);
        tick();
        chk("fe_done", done, 4'b0001);
        req = '0;
        tick();
        tick();

        // Reset in the middle of a transfer on line 2.
        req = 4'b0100;
        wait_launch(ok, n);
        chk("mr_launch", ok, 1);
        chk("mr_id", m_id, 7'h12);
        scl_mon = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_m_rst", m_rst, 1);
        chk("mr_m_valid", m_valid, 0);
        chk("mr_done", done, 0);
        chk("mr_err", err, 0);
        chk("mr_busy", busy, 1);
        rst_n   = 1'b0;
        scl_mon = 1'b1;
        sda_mon = 1'b1;
        req = 4'b1001;
        wait_launch(ok, n);
        chk("mr_relaunch", ok, 1);
        chk("mr_relaunch_gap", n, 2);
        chk("mr_first_grant_id", m_id, 7'h10);
        finish_xfer(d, e, ok);
        chk("mr_done_after", d, 4'b0001);

        // Request drop: line 2 released mid-WAIT still completes; next search starts at 3.
        req = 4'b0101;
        wait_launch(ok, n);
        chk("rd_launch", ok, 1);
        chk("rd_id", m_id, 7'h12);
        tick();
        req = 4'b1001;
        finish_xfer(d, e, ok);
        chk("rd_done", d, 4'b0100);
        wait_launch(ok, n);
        chk("rd_next_launch", ok, 1);
        chk("rd_next_id", m_id, 7'h13);
        finish_xfer(d, e, ok);
        chk("rd_next_done", d, 4'b1000);
        req = '0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
